truth_table_sweeper: RTL and testbench

//  Upstream stimulus and checker stage for the 5-input simplified-logic blocks.

---
 rtl/tt_sweep_pkg.sv | 29 ++
 rtl/tt_settle_timer.sv | 46 ++++
 rtl/truth_table_sweeper.sv | 211 +++++++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_pkg
// Description : Shared types and default constants for the truth-table
//               sweeper: sweep FSM state encoding, default input count,
//               default golden table and the matching vector count.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_sweep_pkg;

    // Default number of DUT inputs (a..e).
    localparam int          N_IN_DEF     = 5;

    // Default golden truth table: bit k is the required output for vector k.
    localparam logic [31:0] EXPECTED_DEF = 32'hCFC89F7F;

    // Number of input vectors for the default configuration.
    localparam int          NVEC         = 2**N_IN_DEF;

    // Sweep controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : tt_sweep_pkg
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : tt_settle_timer
// Description : Loadable down-counter that measures how long a vector is held
//               on the DUT inputs. Loaded with SETTLE-1 when a vector is
//               applied; expired is high once the count reaches zero, so the
//               vector is held for exactly SETTLE cycles.
// Ports       : clk     - clock, rising edge
//               rst_n   - asynchronous active-low reset
//               load    - reload the counter with SETTLE-1
//               en      - count down while high (stops at zero)
//               expired - counter is at zero
// Revision    : 1.0 - initial release
// ============================================================================
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    // Counter is at least one bit wide so SETTLE=1 still elaborates cleanly.
    localparam int               c_tw   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_tw-1:0]  c_load = c_tw'(SETTLE - 1);

    logic [c_tw-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_load;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - {{(c_tw-1){1'b0}}, 1'b1};
        end
    end

    assign expired = (r_cnt == '0);

endmodule : tt_settle_timer
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Stimulus/checker stage for small combinational blocks. Walks
//               every input vector 0..2^N_IN-1 onto dut_in, holds each for
//               SETTLE cycles, samples dut_out for one cycle and compares it
//               with the golden table EXPECTED. Reports pass/fail, the number
//               of failing vectors and the lowest failing vector.
// Options     : SWEEP_LOG_EN - when defined, adds the obs_table port holding
//               the observed truth table (obs_table ^ EXPECTED = error map).
// Ports       : clk, rst_n       - clock / async active-low reset
//               start            - begin a sweep (only honoured in IDLE)
//               dut_in           - registered vector driven to the DUT
//               dut_out          - DUT response, combinational from dut_in
//               busy             - sweep in progress (APPLY/CHECK/DONE)
//               done             - one-cycle end-of-sweep pulse
//               pass             - no mismatches in the last sweep
//               err_count        - number of mismatching vectors
//               first_err_valid  - at least one mismatch seen
//               first_err_idx    - lowest mismatching vector
//               obs_table        - observed table (SWEEP_LOG_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int                  N_IN     = N_IN_DEF,
    parameter logic [2**N_IN-1:0]  EXPECTED = (2**N_IN)'(EXPECTED_DEF),
    parameter int                  SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_count,
    output logic                first_err_valid,
    output logic [N_IN-1:0]     first_err_idx
`ifdef SWEEP_LOG_EN
    ,
    output logic [2**N_IN-1:0]  obs_table
`endif
);

    localparam logic [N_IN-1:0] c_idx_last = '1;
    localparam logic [N_IN-1:0] c_idx_one  = {{(N_IN-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;
    logic               w_timer_load;
    logic               w_timer_en;
    logic               w_timer_expired;

    logic [N_IN-1:0]    r_idx;
    logic [N_IN:0]      r_err_count;
    logic               r_first_valid;
    logic [N_IN-1:0]    r_first_idx;
    logic               r_pass;

    logic               w_mismatch;
    logic               w_last;
    logic [N_IN:0]      w_err_next;

    // ------------------------------------------------------------------
    // Settle timer
    // ------------------------------------------------------------------
    tt_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_timer_load),
        .en      (w_timer_en),
        .expired (w_timer_expired)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_timer_load = 1'b0;
        w_timer_en   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = APPLY;
                    w_timer_load = 1'b1;
                end
            end
            APPLY: begin
                busy       = 1'b1;
                w_timer_en = 1'b1;
                if (w_timer_expired) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    // Reload for the next vector's hold period.
                    w_state_next = APPLY;
                    w_timer_load = 1'b1;
                end
            end
            DONE: begin
                // start is deliberately ignored here; a new sweep needs IDLE.
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Comparator
    // ------------------------------------------------------------------
    assign w_mismatch = dut_out ^ EXPECTED[r_idx];
    assign w_last     = (r_idx == c_idx_last);
    // Cannot overflow: at most 2^N_IN increments into an N_IN+1 bit counter.
    assign w_err_next = r_err_count + {{N_IN{1'b0}}, w_mismatch};

    // ------------------------------------------------------------------
    // Vector index and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_err_count   <= '0;
            r_first_valid <= 1'b0;
            r_first_idx   <= '0;
            r_pass        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx         <= '0;
                        r_err_count   <= '0;
                        r_first_valid <= 1'b0;
                        r_first_idx   <= '0;
                        r_pass        <= 1'b0;
                    end
                end
                CHECK: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_first_valid) begin
                        r_first_valid <= 1'b1;
                        r_first_idx   <= r_idx;
                    end
                    // Verdict is registered on the last check so it is
                    // already valid while done is high.
                    if (w_last) begin
                        r_pass <= (w_err_next == '0);
                    end else begin
                        r_idx <= r_idx + c_idx_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SWEEP_LOG_EN
    // ------------------------------------------------------------------
    // Observed truth table
    // ------------------------------------------------------------------
    logic [2**N_IN-1:0] r_obs_table;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_obs_table <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_obs_table <= '0;
        end else if (r_state == CHECK) begin
            r_obs_table[r_idx] <= dut_out;
        end
    end

    assign obs_table = r_obs_table;
`endif

    assign dut_in          = r_idx;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_valid;
    assign first_err_idx   = r_first_idx;

endmodule : truth_table_sweeper
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Scoreboard bench for truth_table_sweeper. The stimulus side
//               pushes the hand-computed result of each sweep when its start
//               is accepted; per-instance monitors pop and compare whenever
//               done is seen. A second instance runs with SETTLE=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    localparam logic [31:0] GOLD = 32'hCFC89F7F;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    int          mode  = 0;   // 0 golden, 1 tied 0, 2 tied 1, 3 golden with vector 19 inverted

    logic [4:0]  dut_in,  dut_in3;
    logic        dut_out, dut_out3;
    logic        busy, done, pass, fev;
    logic        busy3, done3, pass3, fev3;
    logic [5:0]  err_count, err_count3;
    logic [4:0]  fei, fei3;
`ifdef SWEEP_LOG_EN
    logic [31:0] obs_table, obs_table3;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DUT models
    always_comb begin
        dut_out = GOLD[dut_in];
        case (mode)
            1:       dut_out = 1'b0;
            2:       dut_out = 1'b1;
            3:       dut_out = GOLD[dut_in] ^ (dut_in == 5'd19);
            default: dut_out = GOLD[dut_in];
        endcase
    end
    assign dut_out3 = GOLD[dut_in3];

    truth_table_sweeper u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .dut_in          (dut_in),
        .dut_out         (dut_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_err_valid (fev),
        .first_err_idx   (fei)
`ifdef SWEEP_LOG_EN
        ,
        .obs_table       (obs_table)
`endif
    );

    truth_table_sweeper #(.SETTLE(3)) u_dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start3),
        .dut_in          (dut_in3),
        .dut_out         (dut_out3),
        .busy            (busy3),
        .done            (done3),
        .pass            (pass3),
        .err_count       (err_count3),
        .first_err_valid (fev3),
        .first_err_idx   (fei3)
`ifdef SWEEP_LOG_EN
        ,
        .obs_table       (obs_table3)
`endif
    );

    typedef struct {
        string       name;
        int          t_start;
        int          lat;
        logic [5:0]  err;
        logic        fv;
        logic [4:0]  fidx;
        logic        ps;
        logic [31:0] obs;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   ndone0 = 0;
    int   ndone3 = 0;
    logic done_d0 = 1'b0;
    logic done_d3 = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: main instance
    always @(negedge clk) begin
        if (done_d0) begin
            chk("done_width", {31'd0, done}, 32'd0);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end
        if (done) begin
            ndone0++;
            if (q0.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk({e0.name, "_latency"}, cyc + 1 - e0.t_start, e0.lat);
                chk({e0.name, "_err_count"}, {26'd0, err_count}, {26'd0, e0.err});
                chk({e0.name, "_first_valid"}, {31'd0, fev}, {31'd0, e0.fv});
                chk({e0.name, "_first_idx"}, {27'd0, fei}, {27'd0, e0.fidx});
                chk({e0.name, "_pass"}, {31'd0, pass}, {31'd0, e0.ps});
                chk({e0.name, "_busy"}, {31'd0, busy}, 32'd1);
`ifdef SWEEP_LOG_EN
                chk({e0.name, "_obs_table"}, obs_table, e0.obs);
`endif
            end
        end
        done_d0 <= done;
    end

    // Monitor: SETTLE=3 instance
    always @(negedge clk) begin
        if (done_d3) begin
            chk("s3_done_width", {31'd0, done3}, 32'd0);
        end
        if (done3) begin
            ndone3++;
            if (q3.size() == 0) begin
                chk("s3_unexpected_done", 32'd1, 32'd0);
            end else begin
                e3 = q3.pop_front();
                chk({e3.name, "_latency"}, cyc + 1 - e3.t_start, e3.lat);
                chk({e3.name, "_err_count"}, {26'd0, err_count3}, {26'd0, e3.err});
                chk({e3.name, "_first_valid"}, {31'd0, fev3}, {31'd0, e3.fv});
                chk({e3.name, "_pass"}, {31'd0, pass3}, {31'd0, e3.ps});
`ifdef SWEEP_LOG_EN
                chk({e3.name, "_obs_table"}, obs_table3, e3.obs);
`endif
            end
        end
        done_d3 <= done3;
    end

    // Pulse start for one accepting edge; optionally queue the expected result.
    task automatic run_sweep(input string nm, input bit push, input int lat,
                             input logic [5:0] err, input logic fv,
                             input logic [4:0] fidx, input logic ps,
                             input logic [31:0] obs);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) q0.push_back('{nm, cyc, lat, err, fv, fidx, ps, obs});
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((q0.size() != 0 || q3.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain", q0.size() + q3.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_dut_in"}, {27'd0, dut_in}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_pass"}, {31'd0, pass}, 32'd0);
        chk({nm, "_err_count"}, {26'd0, err_count}, 32'd0);
        chk({nm, "_first_valid"}, {31'd0, fev}, 32'd0);
        chk({nm, "_first_idx"}, {27'd0, fei}, 32'd0);
`ifdef SWEEP_LOG_EN
        chk({nm, "_obs_table"}, obs_table, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int base;
        int t_a;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // 1: golden model
        mode = 0;
        run_sweep("golden", 1'b1, 65, 6'd0, 1'b0, 5'd0, 1'b1, GOLD);
        wait_drain(200);

        // 2: tied 0 -> fails on the 22 ones of the table
        mode = 1;
        run_sweep("tie0", 1'b1, 65, 6'd22, 1'b1, 5'd0, 1'b0, 32'h0000_0000);
        wait_drain(200);

        // 3: tied 1 -> fails on the 10 zeros, lowest zero is bit 7
        mode = 2;
        run_sweep("tie1", 1'b1, 65, 6'd10, 1'b1, 5'd7, 1'b0, 32'hFFFF_FFFF);
        wait_drain(200);

        // 4: one bad vector
        mode = 3;
        run_sweep("flip19", 1'b1, 65, 6'd1, 1'b1, 5'd19, 1'b0, 32'hCFC0_9F7F);
        wait_drain(200);
        repeat (4) @(negedge clk);
        chk("hold_err_count", {26'd0, err_count}, 32'd1);
        chk("hold_first_idx", {27'd0, fei}, 32'd19);
        chk("hold_busy", {31'd0, busy}, 32'd0);

        // 5: abort mid-sweep with reset (tied 0, so results are non-zero first)
        mode = 1;
        base = ndone0;
        run_sweep("abort", 1'b0, 0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        k = 0;
        while (dut_in != 5'd10 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("reach_idx10", {27'd0, dut_in}, 32'd10);
        chk("pre_reset_err", {26'd0, err_count}, 32'd9);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", ndone0, base);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        mode = 0;
        run_sweep("after_reset", 1'b1, 65, 6'd0, 1'b0, 5'd0, 1'b1, GOLD);
        wait_drain(200);

        // 6: start held high -> back-to-back sweeps, one done each.
        // First sweep tied 0, second golden, so stale results would show.
        mode = 1;
        base = ndone0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t_a = cyc;
        q0.push_back('{"held_a", t_a, 65, 6'd22, 1'b1, 5'd0, 1'b0, 32'h0000_0000});
        // DONE cycle, one IDLE cycle, then the next accepting edge.
        q0.push_back('{"held_b", t_a + 66, 65, 6'd0, 1'b0, 5'd0, 1'b1, GOLD});
        @(negedge clk);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        mode = 0;
        @(negedge clk);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_done_count", ndone0 - base, 32'd2);
        chk("held_idle", {31'd0, busy}, 32'd0);
        wait_drain(10);

        // SETTLE=3 instance: 32 * (3 + 1) + 1 cycles
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        q3.push_back('{"settle3", cyc, 129, 6'd0, 1'b0, 5'd0, 1'b1, GOLD});
        wait_drain(400);
        chk("settle3_done_count", ndone3, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_truth_table_sweeper
`default_nettype wire
